// File: rtl/jpeg_spi_slave.sv
// SPI mode-0 slave that streams JPEG bytes from jpeg_data_to_spi to a host MCU.
// Keeps a one-byte prefetch buffer and answers a status poll command.
module jpeg_spi_slave #(
  parameter int          RD_LATENCY = 2,
  parameter logic [7:0]  CMD_READ   = 8'h0B,
  parameter logic [7:0]  CMD_STATUS = 8'h05
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       je_done,
  output logic       spi_rd,
  input  logic [7:0] spi_data,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_DUMMY, S_STREAM, S_STATUS, S_IGNORE
  } state_t;

  state_t r_state, w_state_next;

  logic [2:0]            r_sck_sync, r_cs_sync, r_sync_vld;
  logic [1:0]            r_mosi_sync;
  logic [2:0]            r_bit_cnt;
  logic [6:0]            r_rx;
  logic [7:0]            r_shift, r_buf;
  logic                  r_buf_valid, r_ready, r_underrun;
  logic [RD_LATENCY-1:0] r_rd_pipe;

  logic       w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
  logic       w_boundary, w_fall_bnd, w_fall_mid;
  logic [7:0] w_cmd;
  logic       w_pending, w_capture, w_active;
  logic       w_load_buf, w_load_stat, w_shift, w_rd_req, w_rd_fire, w_clr_underrun;

  assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
  assign w_sck_fall = ~r_sck_sync[1] & r_sck_sync[2];
  assign w_cs_rise  = r_cs_sync[1] & ~r_cs_sync[2];
  // A CS fall counts only once the older sync flop holds a real sample, so a
  // transaction already running when reset releases is never joined mid-way.
  assign w_cs_fall  = r_sync_vld[2] & r_cs_sync[2] & ~r_cs_sync[1];

  assign w_boundary = w_sck_rise & (r_bit_cnt == 3'd7);
  assign w_fall_bnd = w_sck_fall & (r_bit_cnt == 3'd0);
  assign w_fall_mid = w_sck_fall & (r_bit_cnt != 3'd0);
  assign w_cmd      = {r_rx, r_mosi_sync[1]};
  assign w_pending  = |r_rd_pipe;
  assign w_capture  = r_rd_pipe[RD_LATENCY-1];

  always_comb begin
    w_state_next   = r_state;
    w_load_buf     = 1'b0;
    w_load_stat    = 1'b0;
    w_shift        = 1'b0;
    w_rd_req       = 1'b0;
    w_clr_underrun = 1'b0;
    if (w_cs_rise) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_cs_fall) w_state_next = S_CMD;
        S_CMD: begin
          if (w_boundary) begin
            if (w_cmd == CMD_READ) begin
              w_state_next = S_DUMMY;
              w_rd_req     = 1'b1;
            end else if (w_cmd == CMD_STATUS) begin
              w_state_next = S_STATUS;
            end else begin
              w_state_next = S_IGNORE;
            end
          end
        end
        S_DUMMY:  if (w_boundary) w_state_next = S_STREAM;
        S_STREAM: begin
          w_load_buf = w_fall_bnd;
          w_rd_req   = w_fall_bnd;
          w_shift    = w_fall_mid;
        end
        S_STATUS: begin
          w_load_stat = w_fall_bnd;
          w_shift     = w_fall_mid;
          if (w_boundary) begin
            w_state_next   = S_IGNORE;
            w_clr_underrun = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // The buffer being consumed by this cycle's load counts as free for a refill.
  assign w_rd_fire = w_rd_req & r_ready & ~w_pending & (w_load_buf | ~r_buf_valid);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_sck_sync  <= 3'b000;
      r_cs_sync   <= 3'b111;
      r_sync_vld  <= 3'b000;
      r_mosi_sync <= 2'b00;
      r_bit_cnt   <= 3'd0;
      r_rx        <= 7'd0;
      r_shift     <= 8'h00;
      r_buf       <= 8'h00;
      r_buf_valid <= 1'b0;
      r_ready     <= 1'b0;
      r_underrun  <= 1'b0;
      r_rd_pipe   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_sck_sync  <= {r_sck_sync[1:0], spi_sck};
      r_cs_sync   <= {r_cs_sync[1:0], spi_cs_n};
      r_sync_vld  <= {r_sync_vld[1:0], 1'b1};
      r_mosi_sync <= {r_mosi_sync[0], spi_mosi};

      if (w_cs_fall)       r_bit_cnt <= 3'd0;
      else if (w_sck_rise) r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_sck_rise)      r_rx <= {r_rx[5:0], r_mosi_sync[1]};

      if (w_cs_fall)        r_shift <= 8'h00;
      else if (w_load_buf)  r_shift <= r_buf_valid ? r_buf : 8'h00;
      else if (w_load_stat) r_shift <= {6'b0, r_underrun, r_ready};
      else if (w_shift)     r_shift <= {r_shift[6:0], 1'b0};

      r_rd_pipe <= (r_rd_pipe << 1) | RD_LATENCY'(w_rd_fire);

      if (w_capture) begin
        r_buf       <= spi_data;
        r_buf_valid <= 1'b1;
      end else if (w_load_buf) begin
        r_buf_valid <= 1'b0;
      end

      r_ready <= r_ready | je_done;

      if (w_load_buf & ~r_buf_valid) r_underrun <= 1'b1;
      else if (w_clr_underrun)       r_underrun <= 1'b0;
    end
  end

  assign w_active    = (r_state != S_IDLE) & ~w_cs_rise;
  assign busy        = w_active;
  assign spi_miso_oe = w_active;
  assign spi_miso    = w_active & ((r_state == S_STREAM) | (r_state == S_STATUS)) & r_shift[7];
  assign spi_rd      = r_rd_pipe[0];

endmodule
